// File: rtl/rename_map.sv
// rename_map: speculative/architectural register map with in-group bypass and freelist handshake
module rename_map #(
  parameter int WIDTH = 4,
  parameter int LREG = 32,
  parameter int PREG = 64,
  localparam int LBITS = $clog2(LREG),
  localparam int PBITS = $clog2(PREG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       ren_req,
  input  logic [WIDTH-1:0]       ren_dst_v,
  input  logic [WIDTH*LBITS-1:0] ren_src1,
  input  logic [WIDTH*LBITS-1:0] ren_src2,
  input  logic [WIDTH*LBITS-1:0] ren_dst,
  input  logic [WIDTH*PBITS-1:0] fl_rd,
  input  logic [WIDTH-1:0]       fl_v,
  output logic [WIDTH-1:0]       fl_re_,
  output logic [WIDTH-1:0]       fl_we_,
  output logic [WIDTH*PBITS-1:0] fl_wd,
  input  logic [WIDTH-1:0]       commit_v,
  input  logic [WIDTH*LBITS-1:0] commit_ldst,
  input  logic [WIDTH*PBITS-1:0] commit_pdst,
  input  logic [WIDTH*PBITS-1:0] commit_pold,
  output logic                   stall,
  output logic [WIDTH-1:0]       out_v,
  output logic [WIDTH*PBITS-1:0] out_psrc1,
  output logic [WIDTH*PBITS-1:0] out_psrc2,
  output logic [WIDTH*PBITS-1:0] out_pdst,
  output logic [WIDTH*PBITS-1:0] out_pold
);
  logic [PBITS-1:0] smap [LREG];
  logic [PBITS-1:0] amap [LREG];
  logic [PBITS-1:0] smap_nx [LREG];
  logic [PBITS-1:0] amap_nx [LREG];
  logic [PBITS-1:0] pd [WIDTH];
  logic [WIDTH-1:0] dv;
  logic [WIDTH*PBITS-1:0] ps1, ps2, po, pdf;
  logic accept;
  int need, avail;
  assign dv = ren_req & ren_dst_v;
  // each dst slot takes the next freelist entry in slot order
  always_comb begin
    need = 0;
    avail = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pd[i] = fl_rd[need*PBITS +: PBITS];
      need = need + int'(dv[i]);
      avail = avail + int'(fl_v[i]);
    end
  end
  assign accept = ~reset & |ren_req & ~flush & (need <= avail);
  assign stall = ~reset & |ren_req & (flush | (need > avail));
  always_comb begin
    fl_re_ = '1;
    for (int k = 0; k < WIDTH; k++) fl_re_[k] = ~(accept & (k < need));
  end
  // younger slots see older in-group destinations; later matches override earlier
  always_comb begin
    ps1 = '0;
    ps2 = '0;
    po = '0;
    pdf = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ps1[i*PBITS +: PBITS] = smap[ren_src1[i*LBITS +: LBITS]];
      ps2[i*PBITS +: PBITS] = smap[ren_src2[i*LBITS +: LBITS]];
      po[i*PBITS +: PBITS] = smap[ren_dst[i*LBITS +: LBITS]];
      pdf[i*PBITS +: PBITS] = pd[i];
      for (int j = 0; j < i; j++) begin
        if (dv[j] && ren_dst[j*LBITS +: LBITS] == ren_src1[i*LBITS +: LBITS]) ps1[i*PBITS +: PBITS] = pd[j];
        if (dv[j] && ren_dst[j*LBITS +: LBITS] == ren_src2[i*LBITS +: LBITS]) ps2[i*PBITS +: PBITS] = pd[j];
        if (dv[j] && ren_dst[j*LBITS +: LBITS] == ren_dst[i*LBITS +: LBITS]) po[i*PBITS +: PBITS] = pd[j];
      end
    end
  end
  // flush restores from the architectural map including this cycle's commits
  always_comb begin
    amap_nx = amap;
    for (int i = 0; i < WIDTH; i++)
      if (commit_v[i]) amap_nx[commit_ldst[i*LBITS +: LBITS]] = commit_pdst[i*PBITS +: PBITS];
    smap_nx = smap;
    for (int i = 0; i < WIDTH; i++)
      if (accept && dv[i]) smap_nx[ren_dst[i*LBITS +: LBITS]] = pd[i];
    if (flush) smap_nx = amap_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LREG; i++) begin
        smap[i] <= PBITS'(i);
        amap[i] <= PBITS'(i);
      end
      out_v <= '0;
      out_psrc1 <= '0;
      out_psrc2 <= '0;
      out_pdst <= '0;
      out_pold <= '0;
      fl_we_ <= '1;
      fl_wd <= '0;
    end else begin
      smap <= smap_nx;
      amap <= amap_nx;
      out_v <= accept ? ren_req : '0;
      out_psrc1 <= ps1;
      out_psrc2 <= ps2;
      out_pdst <= pdf;
      out_pold <= po;
      fl_we_ <= ~commit_v;
      fl_wd <= commit_pold;
    end
  end
endmodule

// File: tb/tb_rename_map.sv
// tb_rename_map: directed scoreboard bench for rename_map
module tb_rename_map;
  localparam int W = 4, LB = 5, PB = 6;
  typedef struct packed {
    logic [3:0] v, sm, dm, we;
    logic [23:0] s1, s2, pd, po, wd;
  } exp_t;
  logic clk = 1'b0;
  logic reset, flush, stall;
  logic [W-1:0] ren_req, ren_dst_v, fl_v, commit_v, fl_re_, fl_we_, out_v;
  logic [W*LB-1:0] ren_src1, ren_src2, ren_dst, commit_ldst;
  logic [W*PB-1:0] fl_rd, fl_wd, commit_pdst, commit_pold, out_psrc1, out_psrc2, out_pdst, out_pold;
  exp_t q[$];
  exp_t zr;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  rename_map dut (
    .clk(clk), .reset(reset), .flush(flush), .ren_req(ren_req), .ren_dst_v(ren_dst_v),
    .ren_src1(ren_src1), .ren_src2(ren_src2), .ren_dst(ren_dst), .fl_rd(fl_rd), .fl_v(fl_v),
    .fl_re_(fl_re_), .fl_we_(fl_we_), .fl_wd(fl_wd), .commit_v(commit_v), .commit_ldst(commit_ldst),
    .commit_pdst(commit_pdst), .commit_pold(commit_pold), .stall(stall), .out_v(out_v),
    .out_psrc1(out_psrc1), .out_psrc2(out_psrc2), .out_pdst(out_pdst), .out_pold(out_pold)
  );
  function automatic exp_t mk(input logic [3:0] v, sm, dm, we, input logic [23:0] s1, s2, pd, po, wd);
    exp_t e;
    e.v = v; e.sm = sm; e.dm = dm; e.we = we;
    e.s1 = s1; e.s2 = s2; e.pd = pd; e.po = po; e.wd = wd;
    return e;
  endfunction
  function automatic logic [23:0] t4(input int a3, a2, a1, a0);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic clr();
    flush = 0; ren_req = 0; ren_dst_v = 0; fl_v = 0; commit_v = 0;
    ren_src1 = 0; ren_src2 = 0; ren_dst = 0; commit_ldst = 0;
    fl_rd = 0; commit_pdst = 0; commit_pold = 0;
  endtask
  task automatic ren(input int s, input int a, input int b, input int d, input logic dvl);
    ren_req[s] = 1'b1; ren_dst_v[s] = dvl;
    ren_src1[s*LB +: LB] = LB'(a); ren_src2[s*LB +: LB] = LB'(b); ren_dst[s*LB +: LB] = LB'(d);
  endtask
  task automatic fl(input int k, input int tag);
    fl_rd[k*PB +: PB] = PB'(tag); fl_v[k] = 1'b1;
  endtask
  task automatic cm(input int s, input int l, input int p, input int o);
    commit_v[s] = 1'b1; commit_ldst[s*LB +: LB] = LB'(l);
    commit_pdst[s*PB +: PB] = PB'(p); commit_pold[s*PB +: PB] = PB'(o);
  endtask
  // comb outputs checked now; registered outputs queued and checked after the edge
  task automatic step(input logic [3:0] ere, input logic est, input exp_t e);
    exp_t x;
    #1;
    chk("fl_re_", 32'(fl_re_), 32'(ere));
    chk("stall", 32'(stall), 32'(est));
    q.push_back(e);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("out_v", 32'(out_v), 32'(x.v));
    chk("fl_we_", 32'(fl_we_), 32'(x.we));
    chk("fl_wd", 32'(fl_wd), 32'(x.wd));
    for (int s = 0; s < W; s++) begin
      if (x.sm[s]) begin
        chk($sformatf("psrc1[%0d]", s), 32'(out_psrc1[s*PB +: PB]), 32'(x.s1[s*PB +: PB]));
        chk($sformatf("psrc2[%0d]", s), 32'(out_psrc2[s*PB +: PB]), 32'(x.s2[s*PB +: PB]));
      end
      if (x.dm[s]) begin
        chk($sformatf("pdst[%0d]", s), 32'(out_pdst[s*PB +: PB]), 32'(x.pd[s*PB +: PB]));
        chk($sformatf("pold[%0d]", s), 32'(out_pold[s*PB +: PB]), 32'(x.po[s*PB +: PB]));
      end
    end
  endtask
  initial begin
    zr = mk(0, 15, 15, 15, 0, 0, 0, 0, 0);
    reset = 1; clr();
    step(4'b1111, 0, zr);
    clr(); ren(0, 1, 2, 1, 1); fl(0, 40); cm(0, 1, 41, 40); flush = 1;
    step(4'b1111, 0, zr);
    reset = 0; clr(); ren(0, 3, 5, 3, 1); fl(0, 40);
    step(4'b1110, 0, mk(1, 1, 1, 15, t4(0,0,0,3), t4(0,0,0,5), t4(0,0,0,40), t4(0,0,0,3), 0));
    clr(); ren(0, 0, 0, 1, 1); ren(1, 1, 5, 1, 1); fl(0, 40); fl(1, 41);
    step(4'b1100, 0, mk(3, 3, 3, 15, t4(0,0,40,0), t4(0,0,5,0), t4(0,0,41,40), t4(0,0,40,1), 0));
    clr(); ren(0, 1, 2, 1, 1); ren(1, 0, 0, 2, 1); ren(2, 0, 0, 4, 1); fl(0, 50); fl(1, 51);
    step(4'b1111, 1, mk(0, 0, 0, 15, 0, 0, 0, 0, 0));
    clr(); ren(0, 1, 3, 0, 0); ren(1, 2, 4, 2, 1); fl(0, 50);
    step(4'b1110, 0, mk(3, 3, 2, 15, t4(0,0,2,41), t4(0,0,4,40), t4(0,0,50,0), t4(0,0,2,0), 0));
    clr(); flush = 1; ren(0, 1, 1, 1, 1); fl(0, 55);
    step(4'b1111, 1, mk(0, 0, 0, 15, 0, 0, 0, 0, 0));
    clr(); ren(0, 1, 2, 1, 1); fl(0, 51);
    step(4'b1110, 0, mk(1, 1, 1, 15, t4(0,0,0,1), t4(0,0,0,2), t4(0,0,0,51), t4(0,0,0,1), 0));
    clr(); flush = 1; cm(0, 1, 41, 40); cm(1, 6, 46, 6);
    step(4'b1111, 0, mk(0, 0, 0, 4'b1100, 0, 0, 0, 0, t4(0,0,6,40)));
    clr(); ren(0, 1, 6, 6, 1); fl(0, 52);
    step(4'b1110, 0, mk(1, 1, 1, 15, t4(0,0,0,41), t4(0,0,0,46), t4(0,0,0,52), t4(0,0,0,46), 0));
    clr(); cm(1, 7, 47, 7); cm(3, 7, 48, 9); ren(0, 1, 1, 1, 1); ren(1, 2, 2, 2, 1); fl(0, 53);
    step(4'b1111, 1, mk(0, 0, 0, 4'b0101, 0, 0, 0, 0, t4(9,0,7,0)));
    clr(); flush = 1;
    step(4'b1111, 0, mk(0, 0, 0, 15, 0, 0, 0, 0, 0));
    clr(); ren(0, 7, 1, 7, 1); ren(1, 7, 3, 0, 0); ren(2, 0, 7, 7, 1); ren(3, 7, 7, 2, 1);
    fl(0, 60); fl(1, 61); fl(2, 62); fl(3, 63);
    step(4'b1000, 0, mk(15, 15, 4'b1101, 15, t4(61,0,60,48), t4(61,60,3,41), t4(62,61,0,60), t4(2,60,0,48), 0));
    clr(); ren(0, 7, 2, 0, 0);
    step(4'b1111, 0, mk(1, 1, 0, 15, t4(0,0,0,61), t4(0,0,0,62), 0, 0, 0));
    clr(); reset = 1; ren(0, 1, 1, 1, 1); fl(0, 40); cm(0, 1, 44, 43);
    step(4'b1111, 0, zr);
    reset = 0; clr(); ren(0, 1, 7, 1, 1); fl(0, 33);
    step(4'b1110, 0, mk(1, 1, 1, 15, t4(0,0,0,1), t4(0,0,0,7), t4(0,0,0,33), t4(0,0,0,1), 0));
    clr(); flush = 1;
    step(4'b1111, 0, mk(0, 0, 0, 15, 0, 0, 0, 0, 0));
    clr(); ren(0, 1, 6, 0, 0);
    step(4'b1111, 0, mk(1, 1, 0, 15, t4(0,0,0,1), t4(0,0,0,6), 0, 0, 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rename_map.md
RENAME_MAP -- requirements
Module: rename_map

Interface
REQ-001 SHALL have parameter WIDTH, default 4: instructions renamed and committed per cycle; equals freelist READ and WRITE.
REQ-002 SHALL have parameter LREG, default 32: logical registers; LBITS = $clog2(LREG).
REQ-003 SHALL have parameter PREG, default 64: physical tags; PBITS = $clog2(PREG); matches freelist DATA in index mode.
REQ-004 SHALL have ports:
  clk  in  1  single clock, all state on rising edge.
  reset  in  1  synchronous, active-high.
  flush  in  1  active-high; discard speculative mappings.
  ren_req  in  WIDTH  slot i holds an instruction to rename.
  ren_dst_v  in  WIDTH  slot i writes a destination.
  ren_src1, ren_src2, ren_dst  in  WIDTH*LBITS  logical registers per slot.
  fl_rd  in  WIDTH*PBITS  freelist read data, packed from slot 0.
  fl_v  in  WIDTH  freelist read-data valid, prefix-contiguous.
  fl_re_  out  WIDTH  active-low freelist pop.
  fl_we_  out  WIDTH  active-low freelist push.
  fl_wd  out  WIDTH*PBITS  tags returned to the freelist.
  commit_v  in  WIDTH  slot i retires.
  commit_ldst  in  WIDTH*LBITS  retiring logical destination.
  commit_pdst, commit_pold  in  WIDTH*PBITS  retiring new and old tags.
  stall  out  1  rename group not accepted this cycle.
  out_v  out  WIDTH  registered renamed-slot valid.
  out_psrc1, out_psrc2, out_pdst, out_pold  out  WIDTH*PBITS  registered renamed tags.

Function
REQ-005 SHALL hold a speculative map SMAP[LREG] and an architectural map AMAP[LREG] of PBITS entries.
REQ-006 Need count N = popcount(ren_req & ren_dst_v); available count A = popcount(fl_v).
REQ-007 Group SHALL be accepted all-or-nothing, when any ren_req is set, N <= A, and flush = 0; stall = |ren_req & (N > A | flush), combinational.
REQ-008 On accept, the dst slot i SHALL take fl_rd entry k, where k = number of dst slots below i; fl_re_[k] = 0 for k < N, otherwise 1; all fl_re_ = 1 when not accepted.
REQ-009 Source tag of slot i SHALL come from the highest slot j < i with a valid dst and ren_dst[j] = ren_src[i], else from SMAP.
REQ-010 pold for slot i SHALL use the same bypass, applied to ren_dst[i].
REQ-011 SMAP SHALL be updated at the clock edge on accept; for equal ren_dst in one group, the highest slot wins.
REQ-012 out_* SHALL be registered with 1-cycle latency; out_v = ren_req on accept, else 0; out_pdst/out_pold are don't-care where ren_dst_v = 0.
REQ-013 Commit SHALL write AMAP[commit_ldst] = commit_pdst for each commit_v slot; for equal ldst, the highest slot wins.
REQ-014 Commit SHALL register a tag release: next cycle fl_we_[i] = ~commit_v[i] and fl_wd slot i = commit_pold[i].
REQ-015 flush SHALL copy AMAP, including same-cycle commit writes, into SMAP at the edge, with no pop and out_v = 0 next cycle.
REQ-016 Commit SHALL proceed during stall and flush.

Reset
REQ-017 On reset, SMAP[i] and AMAP[i] SHALL be set to i for i < LREG.
REQ-018 On reset, out_v, outputs and fl_wd SHALL be 0; fl_we_ SHALL be all-1.
REQ-019 Reset SHALL override flush, commit and rename in the same cycle.
REQ-020 While reset is high, fl_re_ SHALL be all-1 and stall SHALL be 0.

Verification (WIDTH=4, LREG=32, PREG=64)
REQ-021 After reset, rename slot0 src r3,r5, dst r3, fl_rd[0]=40, fl_v=0001 -> fl_re_=1110; next cycle psrc=3,5, pdst=40, pold=3, out_v=0001.
REQ-022 Slot0 dst r1, slot1 src1 r1 dst r1, fl_rd={41,40}, fl_v=0011 -> slot1 psrc1=40, pold=40, pdst=41; SMAP[1]=41.
REQ-023 Three dst slots, fl_v=0011 -> stall=1, fl_re_=1111, out_v=0 next cycle, SMAP unchanged.
REQ-024 Commit slot0 ldst r1, pdst 41, pold 40 -> next cycle fl_we_=1110, fl_wd[0]=40, AMAP[1]=41.
REQ-025 After REQ-022 with no commit, flush -> SMAP[1]=1; with REQ-024 commit in the flush cycle -> SMAP[1]=41.
REQ-026 Reset asserted mid-group with rename and commit pending -> next cycle out_v=0, fl_we_=1111, SMAP[1]=1.
